// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and constants for the master and slave
package spi_pkg;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

    localparam int SPI_WORD_BITS = 8;

    // Mode encoding is {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - input synchronizer with optional rise/fall detection
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Chain and edge flop share the reset value so reset never fabricates an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= level;
                end
            end

            assign rise = level & ~prev_q;
            assign fall = ~level & prev_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling mode-programmable 8-bit SPI slave
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic [SPI_WORD_BITS-1:0] tx_data,
    output logic [SPI_WORD_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     busy,
    input  logic                     sclk,
    input  logic                     mosi,
    input  logic                     ss_n,
    output logic                     miso,
    output logic                     miso_oe
);

    localparam int CNT_W = $clog2(SPI_WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_WORD_BITS - 1);

    spi_state_t state, next_state;

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level_unused, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    logic                     cpol_q, cpha_q;
    logic [CNT_W-1:0]         bit_cnt;
    logic [SPI_WORD_BITS-1:0] rx_shift, tx_shift;
    logic                     lead_edge, trail_edge, sample_edge, drive_edge;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_ss_sync (
        .clk(clk), .reset(reset), .din(ss_n),
        .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(mosi),
        .level(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge  : trail_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SPI_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SPI_IDLE:   if (ss_fall) next_state = SPI_ACTIVE;
            SPI_ACTIVE: if (ss_rise) next_state = SPI_IDLE;
            default:    next_state = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == SPI_IDLE) begin
                if (ss_fall) begin
                    cpol_q   <= cpol;
                    cpha_q   <= cpha;
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                    tx_shift <= tx_data;
                end
            end else if (ss_rise) begin
                // Deselect wins over any same-cycle sclk edge; partial bytes are dropped
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[SPI_WORD_BITS-2:0], mosi_sync};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        rx_data  <= {rx_shift[SPI_WORD_BITS-2:0], mosi_sync};
                        rx_valid <= 1'b1;
                    end
                end
                if (drive_edge) begin
                    if (bit_cnt == '0) begin
                        tx_shift <= tx_data;
                    end else begin
                        tx_shift <= {tx_shift[SPI_WORD_BITS-2:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miso <= 1'b0;
        end else begin
            miso <= (state == SPI_ACTIVE) & tx_shift[SPI_WORD_BITS-1];
        end
    end

    assign busy    = (state == SPI_ACTIVE);
    assign miso_oe = (state == SPI_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized scoreboard bench for spi_slave
module tb_spi_slave;
    import spi_pkg::*;

    localparam int HP = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic       miso;
    logic       miso_oe;

    int total = 0;
    int bad = 0;
    int valid_seen = 0;
    int valid_expected = 0;
    logic prev_valid = 1'b0;
    logic [7:0] last_rx = 8'h00;

    logic [7:0] exp_rx[$];
    logic [7:0] m_bytes[$];
    logic [7:0] s_bytes[$];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_seen++;
            if (exp_rx.size() == 0) check("unexpected_rx_valid", 32'd1, 32'd0);
            else check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            if (prev_valid) check("rx_valid_width", 32'd2, 32'd1);
        end
        prev_valid = rx_valid;
    end

    // abort_bits>0 truncates the last byte; reset_bit>=0 pulses reset before that bit index of byte 0
    task automatic run_frame(input logic [1:0] mode, input int abort_bits, input int reset_bit);
        int nbytes;
        nbytes = m_bytes.size();
        cpol = mode[1];
        cpha = mode[0];
        sclk = mode[1];
        tx_data = s_bytes[0];
        wait_clks(HP);
        ss_n = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            logic [7:0] got;
            int nb;
            bit full;
            got = 8'h00;
            nb = (abort_bits > 0 && b == nbytes - 1) ? abort_bits : 8;
            full = (nb == 8) && (reset_bit < 0);
            if (full) begin
                exp_rx.push_back(m_bytes[b]);
                valid_expected++;
                last_rx = m_bytes[b];
            end
            for (int i = 7; i >= 8 - nb; i--) begin
                if (reset_bit >= 0 && b == 0 && i == 7 - reset_bit) begin
                    reset = 1'b1;
                    wait_clks(1);
                    reset = 1'b0;
                    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
                    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
                    check("rst_busy", {31'd0, busy}, 32'd0);
                    check("rst_miso", {31'd0, miso}, 32'd0);
                    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
                    last_rx = 8'h00;
                end
                if (!cpha) begin
                    mosi = m_bytes[b][i];
                    wait_clks(HP);
                    got = {got[6:0], miso};
                    sclk = ~cpol;
                    if (i == 0 && b < nbytes - 1) begin
                        wait_clks(7);
                        tx_data = s_bytes[b+1];
                        wait_clks(HP - 7);
                    end else begin
                        wait_clks(HP);
                    end
                    sclk = cpol;
                end else begin
                    if (i == 7 && b > 0) begin
                        wait_clks(7);
                        tx_data = s_bytes[b];
                        wait_clks(HP - 7);
                    end else begin
                        wait_clks(HP);
                    end
                    sclk = ~cpol;
                    mosi = m_bytes[b][i];
                    wait_clks(HP);
                    got = {got[6:0], miso};
                    sclk = cpol;
                end
                if (b == 0 && i == 7 && reset_bit < 0) begin
                    check("busy_active", {31'd0, busy}, 32'd1);
                    check("miso_oe_active", {31'd0, miso_oe}, 32'd1);
                end
            end
            if (full) check("master_rx", {24'd0, got}, {24'd0, s_bytes[b]});
        end
        wait_clks(HP);
        ss_n = 1'b1;
        wait_clks(HP);
        check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("pending_rx", exp_rx.size(), 32'd0);
        check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_rx});
    endtask

    initial begin
        wait_clks(4);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        reset = 1'b0;
        wait_clks(5);

        m_bytes = '{8'hA5}; s_bytes = '{8'h3C};
        run_frame(SPI_MODE0, 0, -1);
        m_bytes = '{8'h5A}; s_bytes = '{8'hC3};
        run_frame(SPI_MODE1, 0, -1);
        run_frame(SPI_MODE2, 0, -1);
        run_frame(SPI_MODE3, 0, -1);

        m_bytes = '{8'h11, 8'h22}; s_bytes = '{8'h81, 8'h42};
        run_frame(SPI_MODE0, 0, -1);

        m_bytes = '{8'h6D}; s_bytes = '{8'h00};
        run_frame(SPI_MODE0, 5, -1);
        m_bytes = '{8'hF0}; s_bytes = '{8'h0F};
        run_frame(SPI_MODE0, 0, -1);

        m_bytes = '{8'hE7}; s_bytes = '{8'h55};
        run_frame(SPI_MODE0, 0, 4);
        m_bytes = '{8'h96}; s_bytes = '{8'h69};
        run_frame(SPI_MODE0, 0, -1);

        cpol = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sclk = ~sclk;
            mosi = 1'($urandom_range(0, 1));
            wait_clks(HP);
            check("sclk_idle_miso_oe", {31'd0, miso_oe}, 32'd0);
        end
        sclk = 1'b0;
        wait_clks(HP);
        m_bytes = '{8'hB4}; s_bytes = '{8'h2E};
        run_frame(SPI_MODE0, 0, -1);

        for (int f = 0; f < 6; f++) begin
            int n;
            logic [1:0] mode;
            n = $urandom_range(1, 3);
            mode = 2'($urandom_range(0, 3));
            m_bytes.delete();
            s_bytes.delete();
            for (int j = 0; j < n; j++) begin
                m_bytes.push_back(8'($urandom));
                s_bytes.push_back(8'($urandom));
            end
            run_frame(mode, 0, -1);
        end

        check("rx_valid_count", valid_seen, valid_expected);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
